game_ctrl: RTL

//  Game sequencer for the VGA square game. Sits between the key inputs, the square

---
 rtl/game_pkg.sv | 32 +++
 rtl/game_ctrl_if.sv | 52 +++++
 rtl/game_ctrl_key_edge.sv | 27 ++
 rtl/game_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg
//  Shared definitions for the VGA square game sequencer:
//   - state_t    : FSM state encoding (also driven out on the debug state port)
//   - LIVES_W    : width of the lives counter
//   - DEF_*      : default frame counts for the READY and HIT holds
//   - cnt_width  : helper that sizes the frame counter for a given frame count
//  Optional feature: GAME_PAUSE_EN (the PAUSE encoding is only used when defined).
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_PLAY  = 3'd2,
        ST_HIT   = 3'd3,
        ST_OVER  = 3'd4,
        ST_PAUSE = 3'd5
    } state_t;

    localparam int LIVES_W          = 2;
    localparam int DEF_SCORE_W      = 4;
    localparam int DEF_LIVES_INIT   = 3;
    localparam int DEF_READY_FRAMES = 60;
    localparam int DEF_HIT_FRAMES   = 30;

    // Bits needed to count 0..frames-1, never less than one bit.
    function automatic int cnt_width(input int frames);
        int w;
        w = $clog2(frames);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// game_ctrl_if
//  Bundles every game_ctrl signal except clk/rst.
//  Modports:
//   master : environment side (drives keys, refr_tick, hit, goal; reads status)
//   slave  : game_ctrl side
//  Signals:
//   refr_tick           1-clk frame pulse
//   start_k/right_k/left_k  key levels
//   pause_k             pause key level (only with GAME_PAUSE_EN)
//   hit/goal            1-clk pulses from the square
//   move_en, turn_r_p, turn_l_p, sq_reset   square controls
//   score, lives, game_over, state          status
interface game_ctrl_if #(
    parameter int SCORE_W = 4
);
    import game_pkg::*;

    logic               refr_tick;
    logic               start_k;
    logic               right_k;
    logic               left_k;
`ifdef GAME_PAUSE_EN
    logic               pause_k;
`endif
    logic               hit;
    logic               goal;
    logic               move_en;
    logic               turn_r_p;
    logic               turn_l_p;
    logic               sq_reset;
    logic [SCORE_W-1:0] score;
    logic [LIVES_W-1:0] lives;
    logic               game_over;
    logic [2:0]         state;

    modport master (
`ifdef GAME_PAUSE_EN
        output pause_k,
`endif
        output refr_tick, start_k, right_k, left_k, hit, goal,
        input  move_en, turn_r_p, turn_l_p, sq_reset, score, lives, game_over, state
    );

    modport slave (
`ifdef GAME_PAUSE_EN
        input  pause_k,
`endif
        input  refr_tick, start_k, right_k, left_k, hit, goal,
        output move_en, turn_r_p, turn_l_p, sq_reset, score, lives, game_over, state
    );

endinterface

// File: rtl/game_ctrl_key_edge.sv
// key_edge
//  One-flop key history and combinational rising-edge detect.
//  Ports:
//   clk  in  clock
//   rst  in  asynchronous reset, active-high (history cleared)
//   key  in  key level, already synchronised
//   rise out key & ~previous key
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic rise
);

    logic prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= key;
        end
    end

    assign rise = key & ~prev_reg;

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl
//  Game sequencer: IDLE -> READY -> PLAY -> (HIT -> READY | OVER) flow, score
//  and lives tracking, per-frame motion gating and key-to-turn-pulse conversion.
//  Ports:
//   clk  in  pixel clock
//   rst  in  asynchronous reset, active-high
//   bus  game_ctrl_if.slave (keys, refr_tick, hit/goal in; square controls and
//        status out)
//  Parameters: SCORE_W, LIVES_INIT, READY_FRAMES, HIT_FRAMES. SCORE_W must
//  match the interface's SCORE_W.
//  Optional feature: GAME_PAUSE_EN adds pause_k and the PAUSE state.
module game_ctrl
    import game_pkg::*;
#(
    parameter int SCORE_W      = DEF_SCORE_W,
    parameter int LIVES_INIT   = DEF_LIVES_INIT,
    parameter int READY_FRAMES = DEF_READY_FRAMES,
    parameter int HIT_FRAMES   = DEF_HIT_FRAMES
) (
    input  logic        clk,
    input  logic        rst,
    game_ctrl_if.slave  bus
);

    localparam int CNT_W = cnt_width((READY_FRAMES > HIT_FRAMES) ? READY_FRAMES : HIT_FRAMES);
    localparam logic [CNT_W-1:0]   READY_LAST = CNT_W'(READY_FRAMES - 1);
    localparam logic [CNT_W-1:0]   HIT_LAST   = CNT_W'(HIT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);

    // Key vector: 0=start, 1=right, 2=left, 3=pause (when enabled)
    localparam int K_START = 0;
    localparam int K_RIGHT = 1;
    localparam int K_LEFT  = 2;
`ifdef GAME_PAUSE_EN
    localparam int K_PAUSE  = 3;
    localparam int NUM_KEYS = 4;
`else
    localparam int NUM_KEYS = 3;
`endif

    logic [NUM_KEYS-1:0] key_lvl;
    logic [NUM_KEYS-1:0] key_rise;

    assign key_lvl[K_START] = bus.start_k;
    assign key_lvl[K_RIGHT] = bus.right_k;
    assign key_lvl[K_LEFT]  = bus.left_k;
`ifdef GAME_PAUSE_EN
    assign key_lvl[K_PAUSE] = bus.pause_k;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_edge u_key_edge (
                .clk  (clk),
                .rst  (rst),
                .key  (key_lvl[gi]),
                .rise (key_rise[gi])
            );
        end
    endgenerate

    state_t             state_reg,     state_next;
    logic [CNT_W-1:0]   frame_cnt_reg, frame_cnt_next;
    logic [SCORE_W-1:0] score_reg,     score_next;
    logic [LIVES_W-1:0] lives_reg,     lives_next;
    logic               sq_reset_reg,  sq_reset_next;
    logic               turn_r_reg,    turn_r_next;
    logic               turn_l_reg,    turn_l_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            frame_cnt_reg <= '0;
            score_reg     <= '0;
            lives_reg     <= LIVES_LOAD;
            sq_reset_reg  <= 1'b0;
            turn_r_reg    <= 1'b0;
            turn_l_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            frame_cnt_reg <= frame_cnt_next;
            score_reg     <= score_next;
            lives_reg     <= lives_next;
            sq_reset_reg  <= sq_reset_next;
            turn_r_reg    <= turn_r_next;
            turn_l_reg    <= turn_l_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        frame_cnt_next = frame_cnt_reg;
        score_next     = score_reg;
        lives_next     = lives_reg;
        sq_reset_next  = 1'b0;
        turn_r_next    = 1'b0;
        turn_l_next    = 1'b0;

        case (state_reg)
            ST_IDLE, ST_OVER: begin
                if (key_rise[K_START]) begin
                    state_next    = ST_READY;
                    score_next    = '0;
                    lives_next    = LIVES_LOAD;
                    sq_reset_next = 1'b1;
                end
            end

            ST_READY: begin
                if (bus.refr_tick) begin
                    if (frame_cnt_reg == READY_LAST) begin
                        state_next = ST_PLAY;
                    end else begin
                        frame_cnt_next = frame_cnt_reg + 1'b1;
                    end
                end
            end

            ST_PLAY: begin
`ifdef GAME_PAUSE_EN
                // Pause wins the cycle: nothing else in PLAY is acted on.
                if (key_rise[K_PAUSE]) begin
                    state_next = ST_PAUSE;
                end else
`endif
                begin
                    // Simultaneous rises are ambiguous, so neither turn fires.
                    turn_r_next = key_rise[K_RIGHT] & ~key_rise[K_LEFT];
                    turn_l_next = key_rise[K_LEFT]  & ~key_rise[K_RIGHT];

                    if (bus.goal && (score_reg != SCORE_MAX)) begin
                        score_next = score_reg + 1'b1;
                    end

                    if (bus.hit) begin
                        lives_next = lives_reg - 1'b1;
                        state_next = (lives_reg <= LIVES_W'(1)) ? ST_OVER : ST_HIT;
                        if (lives_reg == '0) begin
                            lives_next = '0;
                        end
                    end
                end
            end

            ST_HIT: begin
                if (bus.refr_tick) begin
                    if (frame_cnt_reg == HIT_LAST) begin
                        state_next    = ST_READY;
                        sq_reset_next = 1'b1;
                    end else begin
                        frame_cnt_next = frame_cnt_reg + 1'b1;
                    end
                end
            end

`ifdef GAME_PAUSE_EN
            ST_PAUSE: begin
                if (key_rise[K_PAUSE]) begin
                    state_next = ST_PLAY;
                end
            end
`endif

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A tick on the transition edge belongs to the old state; the new
        // state always starts counting from zero.
        if (state_next != state_reg) begin
            frame_cnt_next = '0;
        end
    end

    assign bus.move_en   = (state_reg == ST_PLAY);
    assign bus.game_over = (state_reg == ST_OVER);
    assign bus.turn_r_p  = turn_r_reg;
    assign bus.turn_l_p  = turn_l_reg;
    assign bus.sq_reset  = sq_reset_reg;
    assign bus.score     = score_reg;
    assign bus.lives     = lives_reg;
    assign bus.state     = state_reg;

endmodule
